// File: rtl/dram_timing_pkg.sv
// ----------------------------------------------------------------------------
// dram_timing_pkg
// Shared DRAM timing constants and the refresh FSM state encoding. The access
// sequencer and the refresh scheduler both import this package, so the two
// blocks always agree on CBR phase lengths.
// ----------------------------------------------------------------------------
package dram_timing_pkg;

    // Refresh sequencer states. Each state is a single CBR phase.
    typedef enum logic [1:0] {
        REF_IDLE      = 2'd0,
        REF_CAS_SETUP = 2'd1,
        REF_RAS_ON    = 2'd2,
        REF_PRECHARGE = 2'd3
    } ref_state_t;

    // Default timing in CLK cycles at 7.09 MHz.
    localparam int DEF_REF_INTERVAL = 109;  // 15.4 us -> 512 rows in 8 ms
    localparam int DEF_MAX_DEBT     = 8;    // refreshes that may be owed
    localparam int DEF_CAS_SETUP    = 1;    // tCSR
    localparam int DEF_RAS_LEN      = 2;    // tRAS
    localparam int DEF_PRECHARGE    = 2;    // tRP

    // The refresh debt is reported on a fixed 4-bit port.
    localparam int DEBT_W = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dram_refresh_sched.sv
// ----------------------------------------------------------------------------
// dram_refresh_sched
// CAS-before-RAS refresh scheduler for the FastRAM array. A free-running
// interval counter produces refresh ticks; ticks that cannot be serviced at
// once accumulate as debt. A CBR sequence starts only while the 68000 bus is
// idle and the access sequencer holds no RAS, and once started it always
// runs to completion.
//
// Ports
//   CLK          in   bus clock, all state updates on posedge
//   RESET        in   synchronous, active-high reset
//   ASn          in   synchronised 68000 address strobe, low = bus cycle
//   access_ras   in   access sequencer currently holds RAS
//   ref_cas      out  refresh CAS request (OR'd into both CAS lines)
//   ref_ras      out  refresh RAS request (OR'd into RAS)
//   ref_busy     out  refresh owns the array; access RAS must wait
//   ref_debt     out  outstanding refreshes, 0..MAX_DEBT
//   ref_overflow out  sticky: a tick arrived with the debt already full
// ----------------------------------------------------------------------------
module dram_refresh_sched
    import dram_timing_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL,
    parameter int MAX_DEBT     = DEF_MAX_DEBT,
    parameter int CAS_SETUP    = DEF_CAS_SETUP,
    parameter int RAS_LEN      = DEF_RAS_LEN,
    parameter int PRECHARGE    = DEF_PRECHARGE
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ASn,
    input  logic              access_ras,
    output logic              ref_cas,
    output logic              ref_ras,
    output logic              ref_busy,
    output logic [DEBT_W-1:0] ref_debt,
    output logic              ref_overflow
);

    localparam int CNT_W = $clog2(REF_INTERVAL);
    localparam int PH_W  = $clog2(max3(CAS_SETUP, RAS_LEN, PRECHARGE) + 1);

    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(REF_INTERVAL - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX   = DEBT_W'(MAX_DEBT);
    // Phase counters load N-1 on entry and leave the state when they hit 0.
    localparam logic [PH_W-1:0]   PH_CAS     = PH_W'(CAS_SETUP - 1);
    localparam logic [PH_W-1:0]   PH_RAS     = PH_W'(RAS_LEN - 1);
    localparam logic [PH_W-1:0]   PH_PRE     = PH_W'(PRECHARGE - 1);

    // Every phase must last at least one cycle and the debt must fit 4 bits.
    if (REF_INTERVAL < 2 || MAX_DEBT < 1 || MAX_DEBT > 15 ||
        CAS_SETUP < 1 || RAS_LEN < 1 || PRECHARGE < 1) begin : g_param_check
        $error("dram_refresh_sched: illegal timing parameters");
    end

    logic [CNT_W-1:0] int_cnt;
    logic [PH_W-1:0]  phase;
    ref_state_t       state;
    logic             tick;
    logic             idle_ok;
    logic             start;

    // NOTE: every signal in this block is assigned on every pass, so no
    // latch can be inferred; keep it that way when adding terms.
    always_comb begin
        tick    = (int_cnt == '0);
        idle_ok = ASn & ~access_ras;
        // Uses the debt before this cycle's tick is added.
        start   = (state == REF_IDLE) && (ref_debt != '0) && idle_ok;
    end

    // Free-running interval counter; never stalled by refresh activity.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            int_cnt <= CNT_RELOAD;
        end else if (tick) begin
            int_cnt <= CNT_RELOAD;
        end else begin
            int_cnt <= int_cnt - CNT_W'(1);
        end
    end

    // Debt counter: tick adds, start removes, both together cancel out.
    // A start is only possible with debt > 0, so the count cannot wrap.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ref_debt     <= '0;
            ref_overflow <= 1'b0;
        end else if (tick && !start) begin
            if (ref_debt == DEBT_MAX) begin
                ref_overflow <= 1'b1;
            end else begin
                ref_debt <= ref_debt + DEBT_W'(1);
            end
        end else if (start && !tick) begin
            ref_debt <= ref_debt - DEBT_W'(1);
        end
    end

    // CBR sequencer. Outputs are registered alongside the state so they change
    // on the same edge as the state they belong to. Leaving PRECHARGE always
    // lands in IDLE for at least one cycle, giving the bus an arbitration slot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= REF_IDLE;
            phase    <= '0;
            ref_cas  <= 1'b0;
            ref_ras  <= 1'b0;
            ref_busy <= 1'b0;
        end else begin
            case (state)
                REF_IDLE: begin
                    if (start) begin
                        state    <= REF_CAS_SETUP;
                        phase    <= PH_CAS;
                        ref_cas  <= 1'b1;
                        ref_busy <= 1'b1;
                    end
                end
                REF_CAS_SETUP: begin
                    if (phase == '0) begin
                        state   <= REF_RAS_ON;
                        phase   <= PH_RAS;
                        ref_ras <= 1'b1;
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                REF_RAS_ON: begin
                    if (phase == '0) begin
                        state   <= REF_PRECHARGE;
                        phase   <= PH_PRE;
                        ref_cas <= 1'b0;
                        ref_ras <= 1'b0;
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                REF_PRECHARGE: begin
                    if (phase == '0) begin
                        state    <= REF_IDLE;
                        ref_busy <= 1'b0;
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                default: begin
                    state    <= REF_IDLE;
                    phase    <= '0;
                    ref_cas  <= 1'b0;
                    ref_ras  <= 1'b0;
                    ref_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_refresh_sched.sv
// ----------------------------------------------------------------------------
// tb_dram_refresh_sched
// Directed bench for the CBR refresh scheduler. Each directed step pushes the
// cycle at which it expects ref_cas to rise; a monitor run after every clock
// edge pops that cycle when the rise is seen and checks the CAS/RAS/busy
// pulse shape. Cycle numbers count posedges since RESET was released.
// ----------------------------------------------------------------------------
module tb_dram_refresh_sched;
    import dram_timing_pkg::*;

    localparam int I       = DEF_REF_INTERVAL;
    localparam int CAS_W   = DEF_CAS_SETUP + DEF_RAS_LEN;
    localparam int BUSY_W  = DEF_CAS_SETUP + DEF_RAS_LEN + DEF_PRECHARGE;
    localparam int SEQ_GAP = BUSY_W + 1;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ASn;
    logic       access_ras;
    logic       ref_cas;
    logic       ref_ras;
    logic       ref_busy;
    logic [3:0] ref_debt;
    logic       ref_overflow;

    dram_refresh_sched dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ASn          (ASn),
        .access_ras   (access_ras),
        .ref_cas      (ref_cas),
        .ref_ras      (ref_ras),
        .ref_busy     (ref_busy),
        .ref_debt     (ref_debt),
        .ref_overflow (ref_overflow)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int sb_q[$];

    logic p_cas  = 1'b0;
    logic p_ras  = 1'b0;
    logic p_busy = 1'b0;
    int   cas_t  = 0;
    int   ras_t  = 0;
    int   busy_t = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pulse-shape monitor; skipped while RESET is asserted, since a reset
    // legitimately truncates a sequence.
    task automatic monitor();
        int exp_t;
        if (RESET) begin
            p_cas  = 1'b0;
            p_ras  = 1'b0;
            p_busy = 1'b0;
            return;
        end
        if (ref_cas && !p_cas) begin
            check("sb_expected_start", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                exp_t = sb_q.pop_front();
                check("cas_rise_cycle", cyc, exp_t);
            end
            cas_t = cyc;
        end
        if (ref_ras && !p_ras) begin
            check("ras_after_cas", cyc - cas_t, DEF_CAS_SETUP);
            ras_t = cyc;
        end
        if (!ref_ras && p_ras) check("ras_width", cyc - ras_t, DEF_RAS_LEN);
        if (!ref_cas && p_cas) check("cas_width", cyc - cas_t, CAS_W);
        if (ref_busy && !p_busy) begin
            busy_t = cyc;
            check("busy_with_cas", ref_cas, 1);
        end
        if (!ref_busy && p_busy) check("busy_width", cyc - busy_t, BUSY_W);
        if (access_ras) check("access_ras_while_busy", ref_busy, 0);
        p_cas  = ref_cas;
        p_ras  = ref_ras;
        p_busy = ref_busy;
    endtask

    // NOTE: outputs are sampled 1 time unit after the posedge and inputs are
    // changed there too, so nothing races the active edge.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic run_until(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        // ---- reset: 3 cycles with the bus idle ----
        RESET      = 1'b1;
        ASn        = 1'b1;
        access_ras = 1'b0;
        repeat (3) step();
        check("rst_cas",      ref_cas, 0);
        check("rst_ras",      ref_ras, 0);
        check("rst_busy",     ref_busy, 0);
        check("rst_debt",     ref_debt, 0);
        check("rst_overflow", ref_overflow, 0);
        RESET = 1'b0;
        cyc   = 0;

        // ---- idle bus: one sequence per interval ----
        sb_q.push_back(I + 1);
        sb_q.push_back(2 * I + 1);
        sb_q.push_back(3 * I + 1);
        run_until(I);
        check("first_tick_debt", ref_debt, 1);
        check("first_tick_cas",  ref_cas, 0);
        run_until(3 * I + 13);
        check("idle_debt_drained", ref_debt, 0);

        // ---- bus hog: 5 intervals with ASn low ----
        ASn = 1'b0;
        run_until(8 * I + 13);
        check("hog_debt", ref_debt, 5);
        ASn = 1'b1;
        for (int k = 0; k < 5; k++) sb_q.push_back(8 * I + 14 + SEQ_GAP * k);
        run_until(8 * I + 45);
        check("hog_debt_drained", ref_debt, 0);

        // ---- saturation: access_ras held for 10 intervals ----
        sb_q.push_back(9 * I + 1);
        run_until(9 * I + 10);
        access_ras = 1'b1;
        run_until(17 * I);
        check("sat_debt_full",   ref_debt, 8);
        check("sat_no_overflow", ref_overflow, 0);
        run_until(18 * I);
        check("sat_debt_held",   ref_debt, 8);
        check("sat_overflow",    ref_overflow, 1);
        run_until(19 * I + 10);
        access_ras = 1'b0;
        for (int k = 0; k < 8; k++) sb_q.push_back(19 * I + 11 + SEQ_GAP * k);
        run_until(19 * I + 60);
        check("sat_debt_drained",   ref_debt, 0);
        check("sat_overflow_stick", ref_overflow, 1);

        // ---- start coincides with a tick while debt is 1 ----
        ASn = 1'b0;
        run_until(21 * I - 1);
        check("coinc_debt_before", ref_debt, 1);
        ASn = 1'b1;
        sb_q.push_back(21 * I);
        sb_q.push_back(21 * I + SEQ_GAP);
        step();
        check("coinc_debt_kept", ref_debt, 1);
        run_until(21 * I + 15);
        check("coinc_debt_drained", ref_debt, 0);

        // ---- ASn falls during CAS_SETUP ----
        sb_q.push_back(22 * I + 1);
        run_until(22 * I + 1);
        ASn = 1'b0;
        run_until(22 * I + 4);
        check("strobe_busy_in_pre", ref_busy, 1);
        check("strobe_cas_in_pre",  ref_cas, 0);
        run_until(24 * I + 4);
        check("strobe_debt", ref_debt, 2);

        // ---- reset during RAS_ON ----
        ASn = 1'b1;
        sb_q.push_back(24 * I + 5);
        run_until(24 * I + 6);
        check("midrst_ras_on", ref_ras, 1);
        RESET = 1'b1;
        step();
        check("midrst_cas",      ref_cas, 0);
        check("midrst_ras",      ref_ras, 0);
        check("midrst_busy",     ref_busy, 0);
        check("midrst_debt",     ref_debt, 0);
        check("midrst_overflow", ref_overflow, 0);
        RESET = 1'b0;
        cyc   = 0;

        // Interval counter was reloaded: first sequence timing repeats.
        sb_q.push_back(I + 1);
        run_until(I - 1);
        check("reload_no_tick_yet", ref_debt, 0);
        run_until(I + 10);
        check("sb_all_consumed", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
